// File: rtl/dmem_pkg.sv
// Shared types for the dual-core data-memory arbiter.
// Core ids, request bundle and bus widths.
package dmem_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    typedef enum logic {
        CORE0 = 1'b0,
        CORE1 = 1'b1
    } core_id_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W:1]   addr;
        logic [DATA_W-1:0] wdata;
    } dmem_req_t;

    function automatic core_id_t other_core(input core_id_t c);
        return (c == CORE0) ? CORE1 : CORE0;
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-response tag pipeline: tracks which core owns each
// in-flight read across the fixed memory read latency.
module rd_tag_pipe
    import dmem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     in_valid,
    input  core_id_t in_id,
    output logic     out_valid,
    output core_id_t out_id
);

    logic [RD_LAT-1:0] vld;
    logic [RD_LAT-1:0] ids;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            ids <= '0;
        end else begin
            vld[0] <= in_valid;
            ids[0] <= in_id;
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
                ids[i] <= ids[i-1];
            end
        end
    end

    assign out_valid = vld[RD_LAT-1];
    assign out_id    = core_id_t'(ids[RD_LAT-1]);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single mem read and write ports between two cores:
// one read plus one write per cycle, rotating priority on conflicts.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int WAIT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W:1]   c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_gnt,
    output logic              c0_rvalid,
    output logic [DATA_W-1:0] c0_rdata,
    output logic [WAIT_W-1:0] c0_wait,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W:1]   c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_gnt,
    output logic              c1_rvalid,
    output logic [DATA_W-1:0] c1_rdata,
    output logic [WAIT_W-1:0] c1_wait,
    output logic [ADDR_W:1]   m_raddr,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              m_wen,
    output logic [ADDR_W:1]   m_waddr,
    output logic [DATA_W-1:0] m_wdata
);

    dmem_req_t req0, req1, rreq, wreq;
    core_id_t  prio, prio_nxt, rd_id, wr_id;
    core_id_t  tag_id;
    logic      contest, rd_go, wr_go, tag_vld;
    logic      rd0, rd1, wr0, wr1;
    logic [ADDR_W:1] raddr_q;

    assign req0 = '{we: c0_we, addr: c0_addr, wdata: c0_wdata};
    assign req1 = '{we: c1_we, addr: c1_addr, wdata: c1_wdata};

    // Same-kind requests contend on prio; a read/write pair to the
    // same word lets the write go first so the read sees new data.
    always_comb begin
        c0_gnt  = 1'b0;
        c1_gnt  = 1'b0;
        contest = 1'b0;
        if (!rst_n) begin
            c0_gnt = 1'b0;
        end else if (!(c0_req && c1_req)) begin
            c0_gnt = c0_req;
            c1_gnt = c1_req;
        end else if (req0.we == req1.we) begin
            contest = 1'b1;
            c0_gnt  = (prio == CORE0);
            c1_gnt  = (prio == CORE1);
        end else if (req0.addr == req1.addr) begin
            c0_gnt = req0.we;
            c1_gnt = req1.we;
        end else begin
            c0_gnt = 1'b1;
            c1_gnt = 1'b1;
        end
    end

    assign prio_nxt = contest ? other_core(prio) : prio;

    assign rd0 = c0_gnt & ~req0.we;
    assign rd1 = c1_gnt & ~req1.we;
    assign wr0 = c0_gnt & req0.we;
    assign wr1 = c1_gnt & req1.we;

    assign rd_go = rd0 | rd1;
    assign wr_go = wr0 | wr1;
    assign rd_id = rd1 ? CORE1 : CORE0;
    assign wr_id = wr1 ? CORE1 : CORE0;
    assign rreq  = (rd_id == CORE1) ? req1 : req0;
    assign wreq  = (wr_id == CORE1) ? req1 : req0;

    assign m_wen   = wr_go;
    assign m_waddr = wr_go ? wreq.addr  : '0;
    assign m_wdata = wr_go ? wreq.wdata : '0;
    assign m_raddr = rd_go ? rreq.addr  : raddr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio    <= CORE0;
            raddr_q <= '0;
            c0_wait <= '0;
            c1_wait <= '0;
        end else begin
            prio <= prio_nxt;
            if (rd_go)
                raddr_q <= rreq.addr;
            if (c0_req && !c0_gnt && !(&c0_wait))
                c0_wait <= c0_wait + 1'b1;
            if (c1_req && !c1_gnt && !(&c1_wait))
                c1_wait <= c1_wait + 1'b1;
        end
    end

    rd_tag_pipe #(
        .RD_LAT(RD_LAT)
    ) u_tag (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (rd_go),
        .in_id    (rd_id),
        .out_valid(tag_vld),
        .out_id   (tag_id)
    );

    assign c0_rvalid = tag_vld & (tag_id == CORE0);
    assign c1_rvalid = tag_vld & (tag_id == CORE1);
    assign c0_rdata  = c0_rvalid ? m_rdata : '0;
    assign c1_rdata  = c1_rvalid ? m_rdata : '0;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Responder-side data-memory front end that lets both cores share the single data read port and single write port of `mem`. Each core presents a request/grant data port; the arbiter grants at most one read and one write per cycle, drives `mem`, and returns read data to the issuing core after the fixed memory read latency. It sits at top level between the `core` instances' data ports and `mem`, replacing the direct core-to-mem data wiring.

## Interface
Parameters:
- `RD_LAT`, 1: cycles from `m_raddr` presented to `m_rdata` valid (1..4).
- `WAIT_W`, 16: width of per-core saturating wait counters.

Ports:
- `clk`  in  1  system clock (from `clock`).
- `rst_n`  in  1  asynchronous active-low reset.
- `c0_req` / `c1_req`  in  1  request valid; held stable until granted.
- `c0_we` / `c1_we`  in  1  1 = write, 0 = read.
- `c0_addr` / `c1_addr`  in  [15:1]  word address.
- `c0_wdata` / `c1_wdata`  in  16  write data.
- `c0_gnt` / `c1_gnt`  out  1  request accepted this cycle (combinational).
- `c0_rvalid` / `c1_rvalid`  out  1  read data valid.
- `c0_rdata` / `c1_rdata`  out  16  read data; 0 when rvalid low.
- `c0_wait` / `c1_wait`  out  WAIT_W  cycles req high and gnt low, saturating.
- `m_raddr`  out  [15:1]  to mem data read port.
- `m_rdata`  in  16  from mem data read port.
- `m_wen`  out  1  mem write enable.
- `m_waddr`  out  [15:1]  mem write address.
- `m_wdata`  out  16  mem write data.

## Operation
- Transfer = `cN_req & cN_gnt`; request fields sampled that cycle.
- Classification per cycle: one read + one write from different cores → both granted, unless `c0_addr == c1_addr`; then write granted, read deferred (read-after-write order).
- Two reads or two writes → grant core at `prio`; `prio` flips to the other core after a contested grant only. Uncontested grants leave `prio` unchanged.
- `m_wen` = write transfer; `m_waddr`/`m_wdata` from the granted writer; 0 when no write.
- `m_raddr` from the granted reader; holds previous value when no read.
- Read tag pipeline: RD_LAT-deep shift of {valid, core id}; at output, `cN_rvalid` = valid & id==N, `cN_rdata` = `m_rdata` gated by that rvalid.
- Cores may issue back-to-back reads; responses return in issue order, one per cycle max.
- Wait counters: increment when req & !gnt, hold at all-ones, never clear except reset.

## Timing
- Grant: same cycle as request (combinational from req, we, addr, `prio`).
- Write: committed by mem at the clock edge ending the grant cycle.
- Read: `cN_rvalid` asserted exactly RD_LAT cycles after the grant cycle, for one cycle.
- Reset (async assert, sync-safe deassert): `prio`=0 (core0 first), tag pipeline cleared, rvalid 0, rdata 0, gnt 0, `m_wen` 0, `m_raddr`/`m_waddr`/`m_wdata` 0, wait counters 0.
- Reset mid-read: in-flight reads dropped; no rvalid after reset for pre-reset grants.
- Both req low: no grants, `prio` unchanged, pipeline still shifts.

## Structure
- Package `dmem_pkg`: `ADDR_W`=15, `DATA_W`=16, core-id type (1 bit, `CORE0`/`CORE1`), request struct {we, addr, wdata}.
- Sub-module `rd_tag_pipe`: parameterised RD_LAT shift register of {valid, id} with async active-low reset.
- Arbitration and output muxing stay in `dmem_arbiter`.

## Test plan
- Core0 write addr 0x0010 data 0xBEEF, next cycle core0 read 0x0010 → `m_wen`=1 one cycle; `c0_rvalid`=1 with 0xBEEF RD_LAT cycles after read grant.
- Both read (0x0004, 0x0200) same cycle after reset → core0 granted, core1 next cycle; `c1_wait`=1; `prio`=1 afterwards.
- Core0 read 0x0020 and core1 write 0x0030 same cycle → both granted; `c0_rdata` = old mem[0x0020].
- Core0 read and core1 write both to 0x0040 (data 0x1234) → write granted, read granted next cycle, returns 0x1234.
- Both write continuously for 6 cycles → grants alternate c0,c1,c0,c1,c0,c1; each `wait` = 3.
- Assert `rst_n` low one cycle after a read grant with RD_LAT=2 → no rvalid ever for that read; all outputs 0 during reset.
